// File: rtl/text_grid_renderer_if.sv
// -----------------------------------------------------------------------------
// text_grid_renderer_if
//   Glyph-job handshake between the character-cell renderer (master) and the
//   downstream shape renderer (slave). A job is transferred on a cycle where
//   job_valid and job_ready are both high.
//
//   job_valid         master -> slave  job fields below are meaningful
//   job_ready         slave  -> master slave accepts the job this cycle
//   job_shape         master -> slave  glyph bitmap (GLYPH_BITS)
//   job_fg / job_bg   master -> slave  colour indices after cursor overlay
//   job_base_address  master -> slave  top-left pixel address of the cell
// -----------------------------------------------------------------------------
interface text_grid_renderer_if #(
    parameter int GLYPH_BITS    = 128,
    parameter int FB_ADDR_WIDTH = 20
);
    logic                     job_valid;
    logic                     job_ready;
    logic [GLYPH_BITS-1:0]    job_shape;
    logic [3:0]               job_fg;
    logic [3:0]               job_bg;
    logic [FB_ADDR_WIDTH-1:0] job_base_address;

    modport master (
        output job_valid, job_shape, job_fg, job_bg, job_base_address,
        input  job_ready
    );

    modport slave (
        input  job_valid, job_shape, job_fg, job_bg, job_base_address,
        output job_ready
    );
endinterface

// File: rtl/text_grid_renderer.sv
// -----------------------------------------------------------------------------
// text_grid_renderer
//   Double-buffered character-cell renderer. Once per frame it walks every
//   cell of the text RAM in raster order, fetches the glyph from the font ROM
//   and issues one glyph job per cell (shape, colours, pixel base address) to
//   the shape renderer. Rendering targets the buffer not being displayed; the
//   buffers swap when the VGA scan reports paint_done after a frame finishes.
//
//   clk, rst           clock; asynchronous active-low reset
//   text_addr          text RAM address (line*COLUMNS+col)
//   text_data          {bg, fg, code}, one cycle after text_addr
//   font_addr          font ROM address (character code)
//   font_data          glyph bitmap, one cycle after font_addr
//   cursor_col/line    cursor position, latched at the start of each frame
//   cursor_mode        0 hidden, 1 steady, 2 blink, 3 hidden
//   job                glyph-job handshake (master side)
//   render_busy        downstream is still writing pixels
//   paint_done         pulse: scan of the displayed buffer finished
//   vga_base_address   base address of the displayed buffer
//   frame_done         pulse: every cell of the frame rendered and drained
// -----------------------------------------------------------------------------
module text_grid_renderer #(
    parameter int COLUMNS       = 80,
    parameter int LINES         = 30,
    parameter int CHAR_WIDTH    = 8,
    parameter int CHAR_HEIGHT   = 16,
    parameter int CODE_WIDTH    = 8,
    parameter int FB_ADDR_WIDTH = 20,
    parameter int FRAME_WORDS   = 307200,
    parameter int BLINK_FRAMES  = 16,
    localparam int CELLS        = COLUMNS * LINES,
    localparam int TA_W         = (CELLS > 1) ? $clog2(CELLS) : 1,
    localparam int COL_W        = (COLUMNS > 1) ? $clog2(COLUMNS) : 1,
    localparam int LINE_W       = (LINES > 1) ? $clog2(LINES) : 1,
    localparam int SCREEN_WIDTH = COLUMNS * CHAR_WIDTH,
    localparam int GLYPH_BITS   = CHAR_WIDTH * CHAR_HEIGHT
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [TA_W-1:0]          text_addr,
    input  logic [CODE_WIDTH+7:0]    text_data,
    output logic [CODE_WIDTH-1:0]    font_addr,
    input  logic [GLYPH_BITS-1:0]    font_data,
    input  logic [COL_W-1:0]         cursor_col,
    input  logic [LINE_W-1:0]        cursor_line,
    input  logic [1:0]               cursor_mode,
    text_grid_renderer_if.master     job,
    input  logic                     render_busy,
    input  logic                     paint_done,
    output logic [FB_ADDR_WIDTH-1:0] vga_base_address,
    output logic                     frame_done
);

    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [COL_W-1:0]         LAST_COL    = COL_W'(COLUMNS - 1);
    localparam logic [LINE_W-1:0]        LAST_LINE   = LINE_W'(LINES - 1);
    localparam logic [BLINK_W-1:0]       BLINK_LAST  = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [FB_ADDR_WIDTH-1:0] FRAME_BASE  = FB_ADDR_WIDTH'(FRAME_WORDS);
    localparam logic [FB_ADDR_WIDTH-1:0] LINE_STRIDE = FB_ADDR_WIDTH'(CHAR_HEIGHT * SCREEN_WIDTH);
    localparam logic [FB_ADDR_WIDTH-1:0] COL_STRIDE  = FB_ADDR_WIDTH'(CHAR_WIDTH);

    typedef enum logic [2:0] {
        S_TEXT,
        S_FONT,
        S_SHAPE,
        S_ISSUE,
        S_DRAIN,
        S_WAIT_PAINT
    } stateT;

    stateT                     state;
    logic [COL_W-1:0]          colIdx;
    logic [LINE_W-1:0]         lineIdx;
    logic [TA_W-1:0]           textAddr;
    logic                      displaySel;
    logic [BLINK_W-1:0]        blinkCnt;
    logic                      blinkPhase;

    // Cursor as sampled at cell (0,0); held for the whole frame.
    logic [COL_W-1:0]          latchCol;
    logic [LINE_W-1:0]         latchLine;
    logic [1:0]                latchMode;

    logic [3:0]                cellFg;
    logic [3:0]                cellBg;

    logic                      jobValid;
    logic [GLYPH_BITS-1:0]     jobShape;
    logic [3:0]                jobFg;
    logic [3:0]                jobBg;
    logic [FB_ADDR_WIDTH-1:0]  jobBase;
    logic                      frameDone;

    logic                      cursorHit;
    logic [FB_ADDR_WIDTH-1:0]  renderBase;
    logic [FB_ADDR_WIDTH-1:0]  cellBase;

    // Render into whichever buffer is not on screen.
    assign renderBase = displaySel ? '0 : FRAME_BASE;
    assign cellBase   = renderBase
                      + (FB_ADDR_WIDTH'(lineIdx) * LINE_STRIDE)
                      + (FB_ADDR_WIDTH'(colIdx) * COL_STRIDE);

    // Modes 0 and 3 never draw; a latched position outside the grid never
    // matches a real (col,line) pair.
    assign cursorHit = (colIdx == latchCol) && (lineIdx == latchLine) &&
                       ((latchMode == 2'd1) || ((latchMode == 2'd2) && blinkPhase));

    assign text_addr        = textAddr;
    // NOTE: font_addr is steered straight from text_data while in S_FONT; a
    // registered copy would arrive one cycle late and font_data would not be
    // ready for S_SHAPE. Outside S_FONT it is forced to zero.
    assign font_addr        = (state == S_FONT) ? text_data[CODE_WIDTH-1:0] : '0;
    assign vga_base_address = displaySel ? FRAME_BASE : '0;
    assign frame_done       = frameDone;

    assign job.job_valid        = jobValid;
    assign job.job_shape        = jobShape;
    assign job.job_fg           = jobFg;
    assign job.job_bg           = jobBg;
    assign job.job_base_address = jobBase;

    // NOTE: every register below is updated with non-blocking assignments so
    // that all branches see the pre-edge values of colIdx, lineIdx and state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_TEXT;
            colIdx     <= '0;
            lineIdx    <= '0;
            textAddr   <= '0;
            displaySel <= 1'b0;
            blinkCnt   <= '0;
            blinkPhase <= 1'b0;
            latchCol   <= '0;
            latchLine  <= '0;
            latchMode  <= '0;
            cellFg     <= '0;
            cellBg     <= '0;
            jobValid   <= 1'b0;
            jobShape   <= '0;
            jobFg      <= '0;
            jobBg      <= '0;
            jobBase    <= '0;
            frameDone  <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            case (state)
                S_TEXT: begin
                    // First cell of the frame: freeze the cursor so it cannot
                    // tear if software moves it mid-frame.
                    if ((colIdx == '0) && (lineIdx == '0)) begin
                        latchCol  <= cursor_col;
                        latchLine <= cursor_line;
                        latchMode <= cursor_mode;
                    end
                    state <= S_FONT;
                end
                S_FONT: begin
                    cellBg <= text_data[CODE_WIDTH+7:CODE_WIDTH+4];
                    cellFg <= text_data[CODE_WIDTH+3:CODE_WIDTH];
                    state  <= S_SHAPE;
                end
                S_SHAPE: begin
                    jobShape <= font_data;
                    jobBase  <= cellBase;
                    if (cursorHit) begin
                        jobFg <= cellBg;
                        jobBg <= cellFg;
                    end else begin
                        jobFg <= cellFg;
                        jobBg <= cellBg;
                    end
                    jobValid <= 1'b1;
                    state    <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (job.job_ready) begin
                        jobValid <= 1'b0;
                        if ((colIdx == LAST_COL) && (lineIdx == LAST_LINE)) begin
                            state <= S_DRAIN;
                        end else begin
                            if (colIdx == LAST_COL) begin
                                colIdx  <= '0;
                                lineIdx <= lineIdx + 1'b1;
                            end else begin
                                colIdx <= colIdx + 1'b1;
                            end
                            // Raster order makes the cell index a plain count.
                            textAddr <= textAddr + 1'b1;
                            state    <= S_TEXT;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!render_busy) begin
                        frameDone <= 1'b1;
                        if (blinkCnt == BLINK_LAST) begin
                            blinkCnt   <= '0;
                            blinkPhase <= ~blinkPhase;
                        end else begin
                            blinkCnt <= blinkCnt + 1'b1;
                        end
                        state <= S_WAIT_PAINT;
                    end
                end
                S_WAIT_PAINT: begin
                    // paint_done is only honoured here; earlier pulses are lost.
                    if (paint_done) begin
                        displaySel <= ~displaySel;
                        colIdx     <= '0;
                        lineIdx    <= '0;
                        textAddr   <= '0;
                        state      <= S_TEXT;
                    end
                end
                default: state <= S_TEXT;
            endcase
        end
    end

endmodule

// File: tb/tb_text_grid_renderer.sv
// -----------------------------------------------------------------------------
// tb_text_grid_renderer
//   Directed bench for text_grid_renderer on a 4x2 grid of 8x16 glyphs with a
//   two-frame blink period. Expected glyph jobs are pushed to a queue when each
//   frame is started and popped as the DUT hands jobs over.
// -----------------------------------------------------------------------------
module tb_text_grid_renderer;

    localparam int COLS  = 4;
    localparam int LNS   = 2;
    localparam int CW    = 8;
    localparam int CH    = 16;
    localparam int CODEW = 8;
    localparam int FBW   = 20;
    localparam int FW    = 307200;
    localparam int BLINK = 2;
    localparam int CELLS = COLS * LNS;
    localparam int GB    = CW * CH;

    typedef struct {
        logic [GB-1:0]  shape;
        logic [3:0]     fg;
        logic [3:0]     bg;
        logic [FBW-1:0] base;
    } jobT;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        text_addr;
    logic [CODEW+7:0]  text_data;
    logic [CODEW-1:0]  font_addr;
    logic [GB-1:0]     font_data;
    logic [1:0]        cursor_col;
    logic              cursor_line;
    logic [1:0]        cursor_mode;
    logic              render_busy;
    logic              paint_done;
    logic [FBW-1:0]    vga_base_address;
    logic              frame_done;

    text_grid_renderer_if #(.GLYPH_BITS(GB), .FB_ADDR_WIDTH(FBW)) jobIf ();

    text_grid_renderer #(
        .COLUMNS(COLS), .LINES(LNS), .CHAR_WIDTH(CW), .CHAR_HEIGHT(CH),
        .CODE_WIDTH(CODEW), .FB_ADDR_WIDTH(FBW), .FRAME_WORDS(FW),
        .BLINK_FRAMES(BLINK)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .text_addr        (text_addr),
        .text_data        (text_data),
        .font_addr        (font_addr),
        .font_data        (font_data),
        .cursor_col       (cursor_col),
        .cursor_line      (cursor_line),
        .cursor_mode      (cursor_mode),
        .job              (jobIf),
        .render_busy      (render_busy),
        .paint_done       (paint_done),
        .vga_base_address (vga_base_address),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [GB-1:0] glyph(input logic [CODEW-1:0] code);
        return {8{code, ~code}};
    endfunction

    // Text RAM and font ROM, both with one cycle of read latency.
    logic [CODEW+7:0] textRam [0:CELLS-1];
    always @(posedge clk) begin
        text_data <= textRam[text_addr];
        font_data <= glyph(font_addr);
    end

    int        checks = 0;
    int        errors = 0;
    jobT       expQ[$];
    int        frameDoneCnt = 0;
    logic [FBW-1:0] lastBase = '0;
    int        readyMode = 0;   // 0 ready held high, 1 random, 2 held low
    bit        dispSel = 1'b0;  // model of which buffer is displayed
    int        frameNum = 0;    // model frame index since reset

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // job_ready driver.
    initial begin
        jobIf.job_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       jobIf.job_ready = 1'b1;
                1:       jobIf.job_ready = 1'($urandom_range(0, 1));
                default: jobIf.job_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard consumer and hold-stability monitor.
    initial begin : monitor
        jobT         e;
        logic        stalled;
        logic [156:0] held;
        logic [156:0] cur;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            cur = {jobIf.job_valid, jobIf.job_shape, jobIf.job_fg, jobIf.job_bg, jobIf.job_base_address};
            if (rst !== 1'b1) begin
                stalled = 1'b0;
            end else begin
                if (stalled) check("hold_stable", 160'(cur), 160'(held));
                if (jobIf.job_valid === 1'b1 && jobIf.job_ready === 1'b1) begin
                    check("job_expected", 160'(expQ.size() > 0), 160'(1));
                    if (expQ.size() > 0) begin
                        e = expQ.pop_front();
                        check("job_shape", 160'(jobIf.job_shape), 160'(e.shape));
                        check("job_fg", 160'(jobIf.job_fg), 160'(e.fg));
                        check("job_bg", 160'(jobIf.job_bg), 160'(e.bg));
                        check("job_base", 160'(jobIf.job_base_address), 160'(e.base));
                        lastBase = jobIf.job_base_address;
                    end
                end
                stalled = (jobIf.job_valid === 1'b1) && (jobIf.job_ready !== 1'b1);
                held    = cur;
            end
            if (frame_done === 1'b1) frameDoneCnt++;
        end
    end

    // Expected jobs for one frame, from RAM contents, the cursor inputs as
    // they stand when the frame starts, the blink period and the buffer.
    task automatic pushFrame();
        jobT e;
        int  c;
        int  l;
        bit  hit;
        bit  phase;
        phase = ((frameNum / BLINK) % 2) == 1;
        for (int i = 0; i < CELLS; i++) begin
            c = i % COLS;
            l = i / COLS;
            e.shape = glyph(textRam[i][7:0]);
            e.fg    = textRam[i][11:8];
            e.bg    = textRam[i][15:12];
            hit = (c == int'(cursor_col)) && (l == int'(cursor_line)) &&
                  ((cursor_mode == 2'd1) || ((cursor_mode == 2'd2) && phase));
            if (hit) begin
                e.fg = textRam[i][15:12];
                e.bg = textRam[i][11:8];
            end
            e.base = FBW'((dispSel ? 0 : FW) + l * CH * CW * COLS + c * CW);
            expQ.push_back(e);
        end
        frameNum++;
    endtask

    task automatic waitFrameDone(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_frame_done"}, 160'(frame_done), 160'(1));
    endtask

    task automatic pulsePaint(input string tag);
        @(posedge clk); #1 paint_done = 1'b1;
        @(posedge clk); #1 paint_done = 1'b0;
        check(tag, 160'(vga_base_address), 160'(dispSel ? FW : 0));
    endtask

    task automatic fillPattern();
        for (int i = 0; i < CELLS; i++)
            textRam[i] = {4'(i), 4'(15 - i), 8'(8'h30 + i)};
    endtask

    initial begin
        int n;
        rst         = 1'b0;
        render_busy = 1'b0;
        paint_done  = 1'b0;
        cursor_col  = 2'd1;
        cursor_line = 1'b0;
        cursor_mode = 2'd0;
        fillPattern();

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_job_valid", 160'(jobIf.job_valid), 160'(0));
        check("rst_vga_base", 160'(vga_base_address), 160'(0));
        check("rst_frame_done", 160'(frame_done), 160'(0));
        check("rst_text_addr", 160'(text_addr), 160'(0));
        check("rst_font_addr", 160'(font_addr), 160'(0));

        // Frame 0: mode 0 (no swap), ready held, renders into buffer 1.
        pushFrame();
        @(posedge clk); #1 rst = 1'b1;
        waitFrameDone("f0");
        check("f0_queue_empty", 160'(expQ.size()), 160'(0));
        check("f0_last_base", 160'(lastBase), 160'(FW + 536));
        repeat (5) @(negedge clk);
        check("f0_vga_unswapped", 160'(vga_base_address), 160'(0));
        check("f0_frame_done_once", 160'(frameDoneCnt), 160'(1));

        // Frame 1: swap, blink mode in phase 0, ignored mid-frame paint_done,
        // mid-frame cursor move.
        cursor_col  = 2'd2;
        cursor_line = 1'b1;
        cursor_mode = 2'd2;
        dispSel = ~dispSel;
        pushFrame();
        pulsePaint("f1_swap");
        repeat (6) @(posedge clk);
        #1 paint_done = 1'b1;
        @(posedge clk); #1 paint_done = 1'b0;
        cursor_col  = 2'd0;
        cursor_line = 1'b0;
        cursor_mode = 2'd1;
        check("f1_midframe_paint_ignored", 160'(vga_base_address), 160'(FW));
        waitFrameDone("f1");
        check("f1_queue_empty", 160'(expQ.size()), 160'(0));
        check("f1_vga_held", 160'(vga_base_address), 160'(FW));

        // Frame 2: steady cursor on cell word 3A41, random ready, render_busy
        // held past the last job.
        for (int i = 0; i < CELLS; i++) textRam[i] = 16'h3A41;
        dispSel = ~dispSel;
        pushFrame();
        readyMode   = 1;
        render_busy = 1'b1;
        pulsePaint("f2_swap");
        n = 0;
        while (expQ.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("f2_jobs_drained", 160'(expQ.size()), 160'(0));
        repeat (10) begin
            @(negedge clk);
            check("f2_busy_hold", 160'(frame_done), 160'(0));
        end
        @(posedge clk); #1 render_busy = 1'b0;
        check("f2_busy_edge", 160'(frame_done), 160'(0));
        @(posedge clk); #1;
        check("f2_frame_done_rise", 160'(frame_done), 160'(1));
        @(posedge clk); #1;
        check("f2_frame_done_fall", 160'(frame_done), 160'(0));
        readyMode = 0;

        // Frames 3 and 4: blink mode, phase 1 then phase 0.
        cursor_col  = 2'd3;
        cursor_line = 1'b1;
        cursor_mode = 2'd2;
        dispSel = ~dispSel;
        pushFrame();
        pulsePaint("f3_swap");
        waitFrameDone("f3");
        check("f3_queue_empty", 160'(expQ.size()), 160'(0));
        dispSel = ~dispSel;
        pushFrame();
        pulsePaint("f4_swap");
        waitFrameDone("f4");
        check("f4_queue_empty", 160'(expQ.size()), 160'(0));

        // Frame 5: stall in S_ISSUE, then reset mid-job.
        readyMode = 2;
        dispSel = ~dispSel;
        pushFrame();
        pulsePaint("f5_swap");
        n = 0;
        while (jobIf.job_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("f5_valid_seen", 160'(jobIf.job_valid), 160'(1));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_async_job_valid", 160'(jobIf.job_valid), 160'(0));
        check("rst_async_vga_base", 160'(vga_base_address), 160'(0));
        expQ.delete();
        frameNum    = 0;
        dispSel     = 1'b0;
        cursor_mode = 2'd0;
        readyMode   = 0;
        fillPattern();
        pushFrame();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        waitFrameDone("post_reset");
        check("post_reset_queue_empty", 160'(expQ.size()), 160'(0));
        check("post_reset_vga", 160'(vga_base_address), 160'(0));
        repeat (3) @(negedge clk);
        check("frame_done_total", 160'(frameDoneCnt), 160'(6));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/text_grid_renderer.md
# text_grid_renderer

Parametrised, double-buffered character-cell renderer. It walks every cell of the console text RAM once per frame and looks up each glyph in the font ROM. For each cell it hands one glyph job (shape, colours, pixel base address) to the downstream shape renderer over a valid/ready handshake. It sits between the text RAM / font ROM and the pixel writer, and adds per-cell colour attributes, a blinking cursor overlay and parametrised grid and glyph geometry.

## Interface

Parameters:
- COLUMNS, 80, cells per line
- LINES, 30, lines per screen
- CHAR_WIDTH, 8, glyph width in pixels
- CHAR_HEIGHT, 16, glyph height in pixels
- CODE_WIDTH, 8, character code width; font ROM address width
- FB_ADDR_WIDTH, 20, framebuffer (SRAM) address width
- FRAME_WORDS, 307200, pixel words per buffer; buffer 1 starts at FRAME_WORDS
- BLINK_FRAMES, 16, completed frames per cursor blink phase
- Derived: CELLS = COLUMNS*LINES; TA_W = clog2(CELLS); SCREEN_WIDTH = COLUMNS*CHAR_WIDTH; GLYPH_BITS = CHAR_WIDTH*CHAR_HEIGHT

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- text_addr  out  TA_W  text RAM read address; cell index = line*COLUMNS+col
- text_data  in  CODE_WIDTH+8  cell word {bg[3:0], fg[3:0], code}; 1-cycle read latency
- font_addr  out  CODE_WIDTH  font ROM address
- font_data  in  GLYPH_BITS  glyph bitmap; 1-cycle latency
- cursor_col  in  clog2(COLUMNS)  cursor column
- cursor_line  in  clog2(LINES)  cursor line
- cursor_mode  in  2  0 hidden, 1 steady, 2 blink, 3 treated as hidden
- job_valid  out  1  glyph job valid
- job_ready  in  1  downstream accepts the job
- job_shape  out  GLYPH_BITS  glyph bitmap
- job_fg, job_bg  out  4 each  colour indices after cursor overlay
- job_base_address  out  FB_ADDR_WIDTH  top-left pixel address of the cell
- render_busy  in  1  downstream still writing pixels
- paint_done  in  1  one-cycle pulse; the VGA scan of the displayed buffer has finished
- vga_base_address  out  FB_ADDR_WIDTH  base address of the displayed buffer
- frame_done  out  1  one-cycle pulse when a frame is fully rendered

## Operation

- States: S_TEXT, S_FONT, S_SHAPE, S_ISSUE, S_DRAIN, S_WAIT_PAINT.
- Reset: state S_TEXT; col = line = 0; display_sel = 0; blink_cnt = 0; blink_phase = 0. Every output is 0, so vga_base_address = 0. The cursor latch is loaded on the first S_TEXT cycle.
- vga_base_address = display_sel ? FRAME_WORDS : 0. The render base is the other buffer.
- S_TEXT: text_addr = line*COLUMNS+col → S_FOWNT.
- S_FONT: font_addr = text_data[CODE_WIDTH-1:0]; latch fg and bg from text_data → S_SHAPE.
- S_SHAPE: register job_shape = font_data and job_base_address = render_base + line*CHAR_HEIGHT*SCREEN_WIDTH + col*CHAR_WIDTH (computed modulo 2^FB_ADDR_WIDTH). Apply the cursor overlay → S_ISSUE.
- Cursor overlay: fg and bg are swapped when (col,line) equals the latched cursor and either mode == 1, or mode == 2 and blink_phase == 1. A latched cursor outside the grid draws nothing.
- S_ISSUE: job_valid = 1. All job outputs hold stable until job_ready. On acceptance:
  - If (col,line) == (COLUMNS-1, LINES-1) → S_DRAIN.
  - Otherwise col increments; at COLUMNS-1 col wraps to 0 and line increments → S_TEXT.
- S_DRAIN: wait until render_busy == 0 and job_ready was sampled. Then pulse frame_done and update blink: blink_cnt increments; at BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles → S_WAIT_PAINT.
- S_WAIT_PAINT: on paint_done, toggle display_sel and clear col and line → S_TEXT.
- The cursor inputs are latched on the first S_TEXT of each frame (cell 0,0), so the cursor cannot tear within a frame.

## Timing

- Each cell takes a minimum of 4 cycles (S_TEXT, S_FONT, S_SHAPE, S_ISSUE with job_ready = 1). Each stalled cycle adds one.
- job_valid rises one cycle after S_SHAPE and stays high until the handshake. It is never withdrawn.
- A paint_done outside S_WAIT_PAINT is ignored, not queued.
- The display swap takes effect the cycle after paint_done is sampled in S_WAIT_PAINT. vga_base_address never changes at any other time.
- frame_done is asserted for exactly one cycle per frame, on the S_DRAIN → S_WAIT_PAINT transition.
- Reset asserted mid-frame aborts immediately to the reset state. Any job in flight is dropped, and job_valid falls asynchronously.

## Test plan

- COLUMNS=4, LINES=2, job_ready tied to 1. Run one frame → 8 jobs in raster order, job_base_address for cell (3,1) = FRAME_WORDS + 16*32 + 24 = FRAME_WORDS + 536, frame_done pulses once, vga_base_address stays 0.
- After the first frame, pulse paint_done → vga_base_address = FRAME_WORDS and the next job targets base 0. A paint_done pulsed mid-frame → no swap.
- Toggle job_ready randomly, 50%. Verify job outputs are stable while valid && !ready, with no lost or duplicated cells. Hold render_busy high 10 cycles after the last job → frame_done is delayed exactly until render_busy falls.
- Cell word 0x3A41, cursor at (0,0), mode 1 → job_fg = 3, job_bg = 0xA at cell 0 and no swap elsewhere. Mode 0 → no swap.
- BLINK_FRAMES=2, mode 2 → inverse is absent in frames 0–1, present in frames 2–3, absent in frames 4–5. Cursor moved mid-frame → the change applies from the next frame only.
- Assert rst mid-S_ISSUE → job_valid drops at once. After release, rendering restarts at cell 0 with vga_base_address = 0.
